vld_pulse_shaper: RTL and testbench
===================================

# vld_pulse_shaper

Source-domain (clk_a) stage that feeds the clk_b edge synchronizer. It accepts single-cycle event strobes and turns each one into a clean level pulse on `vld_out`. Every pulse is high for a fixed number of cycles, then low for a fixed number of cycles, so the slower clk_b domain samples each rising edge exactly once. Events that arrive while a pulse is in flight are counted and replayed back-to-back. None are lost unless the pending counter saturates, and overflow is flagged.

## Interface
- `HOLD_CYC`, default 4: clk_a cycles `vld_out` stays high per pulse; legal range ≥1.
- `GAP_CYC`, default 4: clk_a cycles `vld_out` stays low after each pulse; legal range ≥1.
- `CNT_W`, default 4: width of the pending-event counter; saturates at 2^CNT_W−1.
- `clk_a` input 1: sole clock. One clock; reset is asynchronous and active-low.
- `rst_n_a` input 1: asynchronous, active-low reset.
- `evt_in` input 1: event strobe; each high cycle is one event.
- `ovf_clr` input 1: clears sticky `ovf`.
- `vld_out` output 1: shaped level pulse to the downstream clk_b synchronizer.
- `busy` output 1: high while a pulse/gap is running or events are pending.
- `pend_cnt` output CNT_W: events accepted but not yet launched.
- `ovf` output 1: sticky; an event was dropped because the counter was full.

## Operation
- The FSM is a register with three states: IDLE, HOLD and GAP. A down-timer `tmr` is sized for max(HOLD_CYC, GAP_CYC)−1.
- `work` = (pend_cnt != 0) || evt_in.
- `launch` = (state==IDLE && work) || (state==GAP && tmr==0 && work).
- Transitions:
  - IDLE → HOLD on `launch`; load tmr=HOLD_CYC−1.
  - HOLD: decrement tmr; at tmr==0 → GAP, load tmr=GAP_CYC−1.
  - GAP: decrement tmr; at tmr==0 → HOLD if `work` (reload HOLD_CYC−1), else → IDLE.
- `vld_out` = (state==HOLD). It is decoded from a state register bit, so it is glitch-free with no combinational path from inputs.
- Counter update: next = pend_cnt + evt_in − launch.
  - `launch` consumes the oldest event. When pend_cnt==0, that is the same-cycle `evt_in`.
  - If pend_cnt == max, evt_in=1 and launch=0: the event is dropped, pend_cnt holds at max, and `ovf` sets next cycle.
  - If pend_cnt == max, evt_in=1 and launch=1: net zero, no overflow.
- `ovf`: set has priority over `ovf_clr` in the same cycle. Otherwise `ovf_clr` clears it next cycle.
- `busy` = (state != IDLE) || (pend_cnt != 0). It is computed from registers only.
- Sizing rule: HOLD_CYC and GAP_CYC must each span at least two clk_b periods plus one clk_a period. Integrators set them from the clock ratio; the block does not check this.

## Timing
- Reset (async assert, any state, including mid-HOLD):
  - Outputs take these values immediately: `vld_out`=0, `busy`=0, `pend_cnt`=0, `ovf`=0.
  - state=IDLE, tmr=0.
  - Pending events are discarded.
- Release is synchronous to clk_a. The first event is honoured on the first clk_a edge after deassertion.
- Latency: `evt_in` sampled high at edge n while IDLE → `vld_out` high from after edge n through HOLD_CYC cycles.
- Pulse period under backlog is exactly HOLD_CYC+GAP_CYC. GAP→HOLD costs no IDLE cycle.
- Minimum observed low time on `vld_out` between pulses is GAP_CYC. It is never shortened.

## Test plan
All scenarios use defaults: HOLD=4, GAP=4, CNT_W=4. Cycle numbers refer to the cycle after edge n.
- **Reset values:** hold rst_n_a=0, toggle evt_in → all outputs 0. Release with no events → outputs stay 0.
- **Single event:** evt_in at cycle 10 only.
  - `vld_out`=1 on cycles 11–14 and 0 on 15–18.
  - `busy`=1 on 11–18 and 0 from 19.
  - `pend_cnt` stays 0.
- **Burst of 3:** evt_in on cycles 10, 11, 12.
  - `vld_out` high on 11–14, 19–22 and 27–30.
  - `pend_cnt` = 1 @12, 2 @13, 1 @19, 0 @27.
  - `busy` falls @35.
- **Overflow:** evt_in high on cycles 10–29 (20 events).
  - `pend_cnt` reaches 15 @28; events at cycles 28 and 29 are dropped.
  - `ovf`=1 from cycle 29.
  - Exactly 18 pulses are produced.
- **Clear vs set:** `ovf_clr` pulsed in the same cycle as a drop → `ovf` stays 1. A later lone `ovf_clr` → `ovf`=0 next cycle.
- **Reset mid-pulse:** assert rst_n_a on cycle 12 of the burst scenario.
  - `vld_out` falls asynchronously and `pend_cnt`=0.
  - After release with no events, no further pulses occur.

Source files
------------

// File: rtl/vld_pulse_shaper_if.sv
// Event / shaped-pulse bundle between the event source and vld_pulse_shaper.
interface vld_pulse_shaper_if #(
    parameter int CNT_W = 4
);
    logic             evt_in;
    logic             ovf_clr;
    logic             vld_out;
    logic             busy;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;

    // Event source side
    modport master (
        output evt_in,
        output ovf_clr,
        input  vld_out,
        input  busy,
        input  pend_cnt,
        input  ovf
    );

    // Shaper side
    modport slave (
        input  evt_in,
        input  ovf_clr,
        output vld_out,
        output busy,
        output pend_cnt,
        output ovf
    );
endinterface

// File: rtl/vld_pulse_shaper.sv
// Turns single-cycle event strobes into fixed-width level pulses separated by
// a fixed low gap, so a slower clk_b domain samples every rising edge once.
// Events arriving during a pulse are counted and replayed back-to-back.
module vld_pulse_shaper #(
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int CNT_W    = 4
) (
    input  logic                clk_a,
    input  logic                rst_n_a,
    vld_pulse_shaper_if.slave   bus
);

    localparam int TMR_MAX = ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC) - 1;
    localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Bit 0 is set only in HOLD so vld_out comes straight off a flop.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             work;
    logic             launch;
    logic             drop;

    // Pending-counter step with saturation: returns {drop, next_count}.
    // A launch while full and receiving an event nets to zero, no drop.
    function automatic logic [CNT_W:0] pend_step(
        input logic [CNT_W-1:0] cnt,
        input logic             add,
        input logic             sub
    );
        if (add && !sub && (cnt == CNT_MAX)) begin
            return {1'b1, cnt};
        end else if (add && !sub) begin
            return {1'b0, cnt + 1'b1};
        end else if (!add && sub) begin
            return {1'b0, cnt - 1'b1};
        end else begin
            return {1'b0, cnt};
        end
    endfunction

    // Launch decision and counter next value.
    always_comb begin
        work   = (cnt_q != '0) || bus.evt_in;
        launch = work && ((state_q == IDLE) ||
                          ((state_q == GAP) && (tmr_q == '0)));
        {drop, cnt_d} = pend_step(cnt_q, bus.evt_in, launch);
    end

    // State and timer register.
    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Next-state logic: HOLD and GAP each run their timer down to zero;
    // GAP goes straight back to HOLD when more work is waiting.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = HOLD;
                    tmr_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (tmr_q == '0) begin
                    state_d = GAP;
                    tmr_d   = GAP_LOAD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == '0) begin
                    if (work) begin
                        state_d = HOLD;
                        tmr_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Pending counter and sticky overflow; a drop wins over a same-cycle clear.
    always_ff @(posedge clk_a or negedge rst_n_a) begin
        if (!rst_n_a) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Outputs decoded from registers only.
    always_comb begin
        bus.vld_out  = state_q[0];
        bus.busy     = (state_q != IDLE) || (cnt_q != '0);
        bus.pend_cnt = cnt_q;
        bus.ovf      = ovf_q;
    end

endmodule

// File: tb/tb_vld_pulse_shaper.sv
// Directed plus randomized bench for vld_pulse_shaper against a timeline
// model: a pulse launched at edge L is high for cycles L+1..L+HOLD and the
// next launch is allowed from edge L+HOLD+GAP onward.
module tb_vld_pulse_shaper;

    localparam int HOLD  = 4;
    localparam int GAP   = 4;
    localparam int CW    = 4;
    localparam int PMAX  = (1 << CW) - 1;

    logic clk_a;
    logic rst_n_a;

    vld_pulse_shaper_if #(.CNT_W(CW)) bus ();

    vld_pulse_shaper #(
        .HOLD_CYC (HOLD),
        .GAP_CYC  (GAP),
        .CNT_W    (CW)
    ) dut (
        .clk_a   (clk_a),
        .rst_n_a (rst_n_a),
        .bus     (bus)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int n      = 0;      // edge index
    int last_l = -1000;  // edge of most recent launch
    int pend   = 0;
    bit m_ovf  = 1'b0;
    bit e_vld;
    bit e_busy;

    int rise_cnt = 0;
    bit prev_vld = 1'b0;
    int peak_pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_vld"},  {31'd0, bus.vld_out}, {31'd0, e_vld});
        chk({tag, "_busy"}, {31'd0, bus.busy},    {31'd0, e_busy});
        chk({tag, "_pend"}, {28'd0, bus.pend_cnt}, pend);
        chk({tag, "_ovf"},  {31'd0, bus.ovf},     {31'd0, m_ovf});
    endtask

    // One clock with the given inputs, model update, then output check.
    task automatic step(input logic e, input logic c, input string tag);
        bit work;
        bit launch;
        @(negedge clk_a);
        bus.evt_in  = e;
        bus.ovf_clr = c;
        @(posedge clk_a);
        work   = (pend > 0) || e;
        launch = work && (n >= last_l + HOLD + GAP);
        if (launch) last_l = n;
        if (e && !launch && pend == PMAX) begin
            m_ovf = 1'b1;
        end else begin
            pend = pend + int'(e) - int'(launch);
            if (c) m_ovf = 1'b0;
        end
        e_vld  = (n < last_l + HOLD);
        e_busy = (n < last_l + HOLD + GAP) || (pend > 0);
        n++;
        #1;
        chk_all(tag);
        if (bus.vld_out === 1'b1 && !prev_vld) rise_cnt++;
        prev_vld = (bus.vld_out === 1'b1);
        if (int'(bus.pend_cnt) > peak_pend) peak_pend = int'(bus.pend_cnt);
    endtask

    task automatic model_reset();
        pend   = 0;
        m_ovf  = 1'b0;
        last_l = -1000;
        e_vld  = 1'b0;
        e_busy = 1'b0;
        prev_vld = 1'b0;
    endtask

    // Hold reset for some cycles while toggling evt_in, then release at negedge.
    task automatic hold_reset(input int cycles, input string tag);
        #1;
        model_reset();
        chk_all({tag, "_async"});
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_a);
            bus.evt_in  = 1'($urandom_range(0, 1));
            bus.ovf_clr = 1'b0;
            @(posedge clk_a);
            n++;
            #1;
            chk_all({tag, "_held"});
        end
        @(negedge clk_a);
        bus.evt_in = 1'b0;
        rst_n_a    = 1'b1;
    endtask

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        int dens;
        rst_n_a     = 1'b0;
        bus.evt_in  = 1'b0;
        bus.ovf_clr = 1'b0;
        e_vld  = 1'b0;
        e_busy = 1'b0;

        // Reset values, then release with no events
        hold_reset(4, "rst");
        idle(5, "rst_rel");

        // Single event
        step(1'b1, 1'b0, "single");
        idle(12, "single");

        // Burst of three
        step(1'b1, 1'b0, "burst");
        step(1'b1, 1'b0, "burst");
        step(1'b1, 1'b0, "burst");
        idle(26, "burst");

        // Overflow: 20 back-to-back events, clear coinciding with the last drop
        rise_cnt  = 0;
        peak_pend = 0;
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, "ovf_fill");
        step(1'b1, 1'b1, "ovf_clrset");
        idle(150, "ovf_drain");
        chk("ovf_pulses", rise_cnt, 18);
        chk("ovf_peak_pend", peak_pend, PMAX);
        chk("ovf_sticky", {31'd0, bus.ovf}, 1);
        step(1'b0, 1'b1, "ovf_clr");
        chk("ovf_cleared", {31'd0, bus.ovf}, 0);
        idle(2, "ovf_clr");

        // Reset mid-pulse during a burst
        step(1'b1, 1'b0, "midrst");
        step(1'b1, 1'b0, "midrst");
        step(1'b1, 1'b0, "midrst");
        rst_n_a = 1'b0;
        hold_reset(2, "midrst");
        rise_cnt = 0;
        idle(30, "midrst_rel");
        chk("midrst_no_pulse", rise_cnt, 0);

        // Randomized traffic with varying density and occasional clears
        for (int blk = 0; blk < 10; blk++) begin
            case (blk % 4)
                0: dens = 5;
                1: dens = 30;
                2: dens = 70;
                default: dens = 100;
            endcase
            for (int i = 0; i < 80; i++) begin
                step(1'($urandom_range(0, 99) < dens),
                     1'($urandom_range(0, 15) == 0), "rand");
            end
            if (blk == 5) begin
                rst_n_a = 1'b0;
                hold_reset(1, "rand_rst");
            end
        end
        idle(150, "rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
